// File: rtl/sleepwell_ball_motion.sv
// rtl/sleepwell_ball_motion.sv - frame-rate ball motion controller with debounced controls
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse at the start of each frame; all updates happen here
//   btn_pause           raw button, toggles RUN/PAUSE on press
//   btn_speed_up/dn     raw buttons, step speed within 1..MAX_SPEED on press
//   btn_center          raw button, recentres the ball on press
//   ball_x, ball_y      ball centre in pixels
//   speed               current speed in pixels/frame
//   paused              high while in PAUSE
//   bounce              one-cycle pulse after a frame with any wall reversal
//   hit_count           frames containing a bounce, wraps at 255
module sleepwell_ball_motion #(
    parameter int BALL_SIZE       = 20,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int INIT_SPEED      = 2,
    parameter int MAX_SPEED       = 7,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_pause,
    input  logic       btn_speed_up,
    input  logic       btn_speed_dn,
    input  logic       btn_center,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [2:0] speed,
    output logic       paused,
    output logic       bounce,
    output logic [7:0] hit_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // Button bit positions inside the synchronizer/debounce vectors.
    localparam int B_PAUSE  = 0;
    localparam int B_UP     = 1;
    localparam int B_DN     = 2;
    localparam int B_CENTER = 3;

    localparam logic [10:0] X_HI     = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_HI     = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] LO       = 11'(BALL_SIZE);
    localparam logic [9:0]  X_HI_POS = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  Y_HI_POS = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  LO_POS   = 10'(BALL_SIZE);
    localparam logic [9:0]  X_MID    = 10'(H_ACTIVE / 2);
    localparam logic [9:0]  Y_MID    = 10'(V_ACTIVE / 2);
    localparam logic [2:0]  SPD_INIT = 3'(INIT_SPEED);
    localparam logic [2:0]  SPD_MAX  = 3'(MAX_SPEED);
    localparam logic [3:0]  DB_N     = 4'(DEBOUNCE_FRAMES);

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      db_lvl_q, db_lvl_d;
    logic [3:0][3:0] db_cnt_q, db_cnt_d;
    logic [9:0]      ball_x_q, ball_x_d;
    logic [9:0]      ball_y_q, ball_y_d;
    logic            dir_x_neg_q, dir_x_neg_d;
    logic            dir_y_neg_q, dir_y_neg_d;
    logic [2:0]      speed_q, speed_d;
    logic            bounce_q, bounce_d;
    logic [7:0]      hit_count_q, hit_count_d;

    logic [3:0]      press_ev;
    logic [10:0]     x_sum, y_sum, lo_sum;
    logic            x_hit_hi, x_hit_lo, y_hit_hi, y_hit_lo;
    logic            any_bounce;

    // 11-bit sums so that pos+speed near 1023 can never wrap into a false miss.
    assign x_sum    = {1'b0, ball_x_q} + {8'b0, speed_q};
    assign y_sum    = {1'b0, ball_y_q} + {8'b0, speed_q};
    assign lo_sum   = LO + {8'b0, speed_q};
    assign x_hit_hi = (x_sum >= X_HI);
    assign y_hit_hi = (y_sum >= Y_HI);
    assign x_hit_lo = ({1'b0, ball_x_q} <= lo_sum);
    assign y_hit_lo = ({1'b0, ball_y_q} <= lo_sum);

    always_comb begin
        state_d     = state_q;
        sync1_d     = {btn_center, btn_speed_dn, btn_speed_up, btn_pause};
        sync2_d     = sync1_q;
        db_lvl_d    = db_lvl_q;
        db_cnt_d    = db_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;
        speed_d     = speed_q;
        bounce_d    = 1'b0;
        hit_count_d = hit_count_q;
        press_ev    = 4'b0;
        any_bounce  = 1'b0;

        if (frame_tick) begin
            // Debounce: a level must differ for DB_N consecutive ticks before it is
            // accepted; only the rising acceptance is an action event.
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != db_lvl_q[i]) begin
                    if (db_cnt_q[i] + 4'd1 == DB_N) begin
                        db_lvl_d[i] = ~db_lvl_q[i];
                        db_cnt_d[i] = 4'd0;
                        press_ev[i] = ~db_lvl_q[i];
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                    end
                end else begin
                    db_cnt_d[i] = 4'd0;
                end
            end

            // Motion uses the pre-tick state and speed; centre overrides it.
            if (press_ev[B_CENTER]) begin
                ball_x_d    = X_MID;
                ball_y_d    = Y_MID;
                dir_x_neg_d = 1'b0;
                dir_y_neg_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                if (!dir_x_neg_q) begin
                    if (x_hit_hi) begin
                        ball_x_d    = X_HI_POS;
                        dir_x_neg_d = 1'b1;
                        any_bounce  = 1'b1;
                    end else begin
                        ball_x_d = x_sum[9:0];
                    end
                end else begin
                    if (x_hit_lo) begin
                        ball_x_d    = LO_POS;
                        dir_x_neg_d = 1'b0;
                        any_bounce  = 1'b1;
                    end else begin
                        ball_x_d = ball_x_q - {7'b0, speed_q};
                    end
                end

                if (!dir_y_neg_q) begin
                    if (y_hit_hi) begin
                        ball_y_d    = Y_HI_POS;
                        dir_y_neg_d = 1'b1;
                        any_bounce  = 1'b1;
                    end else begin
                        ball_y_d = y_sum[9:0];
                    end
                end else begin
                    if (y_hit_lo) begin
                        ball_y_d    = LO_POS;
                        dir_y_neg_d = 1'b0;
                        any_bounce  = 1'b1;
                    end else begin
                        ball_y_d = ball_y_q - {7'b0, speed_q};
                    end
                end
            end

            bounce_d = any_bounce;
            if (any_bounce) begin
                hit_count_d = hit_count_q + 8'd1;
            end

            if (press_ev[B_PAUSE]) begin
                state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            end

            // Simultaneous up and down cancel out.
            if (press_ev[B_UP] && !press_ev[B_DN]) begin
                if (speed_q < SPD_MAX) begin
                    speed_d = speed_q + 3'd1;
                end
            end else if (press_ev[B_DN] && !press_ev[B_UP]) begin
                if (speed_q > 3'd1) begin
                    speed_d = speed_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sync1_q     <= 4'b0;
            sync2_q     <= 4'b0;
            db_lvl_q    <= 4'b0;
            db_cnt_q    <= '0;
            ball_x_q    <= X_MID;
            ball_y_q    <= Y_MID;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
            speed_q     <= SPD_INIT;
            bounce_q    <= 1'b0;
            hit_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_lvl_q    <= db_lvl_d;
            db_cnt_q    <= db_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_neg_q <= dir_x_neg_d;
            dir_y_neg_q <= dir_y_neg_d;
            speed_q     <= speed_d;
            bounce_q    <= bounce_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign speed     = speed_q;
    assign paused    = (state_q == ST_PAUSE);
    assign bounce    = bounce_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_sleepwell_ball_motion.sv
// tb/tb_sleepwell_ball_motion.sv - randomized and directed bench for sleepwell_ball_motion
module tb_sleepwell_ball_motion;

    localparam int BS   = 20;
    localparam int HA   = 640;
    localparam int VA   = 480;
    localparam int SPD0 = 2;
    localparam int SMAX = 7;
    localparam int DB   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] btns = 4'b0;   // {center, dn, up, pause}
    logic [9:0] ball_x, ball_y;
    logic [2:0] speed;
    logic       paused, bounce;
    logic [7:0] hit_count;

    always #5 clk = ~clk;

    sleepwell_ball_motion #(
        .BALL_SIZE(BS), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .INIT_SPEED(SPD0), .MAX_SPEED(SMAX), .DEBOUNCE_FRAMES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_pause(btns[0]), .btn_speed_up(btns[1]),
        .btn_speed_dn(btns[2]), .btn_center(btns[3]),
        .ball_x(ball_x), .ball_y(ball_y), .speed(speed),
        .paused(paused), .bounce(bounce), .hit_count(hit_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integers, direction as +1/-1.
    int m_x, m_y, m_dx, m_dy, m_spd, m_paused, m_hits, m_bnc;
    int m_cnt[4];
    int m_lvl[4];

    task automatic model_reset();
        m_x = HA / 2; m_y = VA / 2; m_dx = 1; m_dy = 1;
        m_spd = SPD0; m_paused = 0; m_hits = 0; m_bnc = 0;
        for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_lvl[i] = 0; end
    endtask

    task automatic move(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + m_spd >= lim - BS) begin p = lim - BS; d = -1; m_bnc = 1; end
            else p = p + m_spd;
        end else begin
            if (p <= BS + m_spd) begin p = BS; d = 1; m_bnc = 1; end
            else p = p - m_spd;
        end
    endtask

    task automatic model_step(input logic [3:0] b);
        int ev[4];
        for (int i = 0; i < 4; i++) begin
            ev[i] = 0;
            if (int'(b[i]) != m_lvl[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == DB) begin
                    m_lvl[i] = 1 - m_lvl[i];
                    m_cnt[i] = 0;
                    ev[i] = m_lvl[i];
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        m_bnc = 0;
        if (ev[3] != 0) begin
            m_x = HA / 2; m_y = VA / 2; m_dx = 1; m_dy = 1;
        end else if (m_paused == 0) begin
            move(m_x, m_dx, HA);
            move(m_y, m_dy, VA);
        end
        if (ev[0] != 0) m_paused = 1 - m_paused;
        if (ev[1] != 0 && ev[2] == 0 && m_spd < SMAX) m_spd++;
        if (ev[2] != 0 && ev[1] == 0 && m_spd > 1) m_spd--;
        if (m_bnc != 0) m_hits = (m_hits + 1) % 256;
    endtask

    // Ticks until the next wall reversal if nothing is pressed; -1 if none found.
    function automatic int ticks_to_bounce();
        int x = m_x, y = m_y, dx = m_dx, dy = m_dy;
        for (int k = 1; k <= 2000; k++) begin
            bit hit = 0;
            if (dx > 0) begin if (x + m_spd >= HA - BS) hit = 1; else x += m_spd; end
            else begin if (x <= BS + m_spd) hit = 1; else x -= m_spd; end
            if (dy > 0) begin if (y + m_spd >= VA - BS) hit = 1; else y += m_spd; end
            else begin if (y <= BS + m_spd) hit = 1; else y -= m_spd; end
            if (hit) return k;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("ball_x", int'(ball_x), m_x);
        chk("ball_y", int'(ball_y), m_y);
        chk("speed", int'(speed), m_spd);
        chk("paused", int'(paused), m_paused);
        chk("bounce", int'(bounce), m_bnc);
        chk("hit_count", int'(hit_count), m_hits);
    endtask

    // One frame update. Without b2b, two idle edges let button changes
    // reach the synchronizer output and confirm the bounce pulse dropped.
    task automatic tick(input bit b2b);
        if (!b2b) begin
            @(posedge clk); #1;
            chk("bounce_low", int'(bounce), 0);
            @(posedge clk);
        end
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_step(btns);
        check_outputs();
    endtask

    task automatic run(input int n, input logic [3:0] b);
        btns = b;
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic press(input logic [3:0] b);
        run(DB, b);
        run(DB, 4'b0);
    endtask

    initial begin
        int guard;
        int found;
        int sx, sy, pre_hits;
        logic [3:0] nb;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_ball_x", int'(ball_x), 320);
        chk("rst_ball_y", int'(ball_y), 240);
        chk("rst_speed", int'(speed), SPD0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_bounce", int'(bounce), 0);
        chk("rst_hits", int'(hit_count), 0);

        // Free run: Y hits the bottom wall at tick 110, X the right wall at 150.
        run(110, 4'b0);
        chk("t110_ball_y", int'(ball_y), 460);
        chk("t110_bounce", int'(bounce), 1);
        chk("t110_hits", int'(hit_count), 1);
        run(40, 4'b0);
        chk("t150_ball_x", int'(ball_x), 620);
        chk("t150_hits", int'(hit_count), 2);

        // Five speed-up events saturate at the ceiling.
        for (int i = 0; i < 5; i++) press(4'b0010);
        chk("speed_sat", int'(speed), 7);

        // Centre, then run right at speed 7: 614 + 7 would overshoot, clamps to 620.
        press(4'b1000);
        found = 0;
        for (guard = 0; guard < 200 && found == 0; guard++) begin
            run(1, 4'b0);
            if (m_bnc != 0 && m_dx < 0 && m_x == HA - BS) found = 1;
        end
        chk("clamp_found", found, 1);
        chk("clamp_ball_x", int'(ball_x), 620);

        for (int i = 0; i < 5; i++) press(4'b0100);
        chk("speed_floor2", int'(speed), 2);

        // Three-tick hold is rejected; four-tick hold is accepted.
        run(3, 4'b0010);
        run(DB, 4'b0);
        chk("speed_short_hold", int'(speed), 2);
        run(4, 4'b0010);
        chk("speed_long_hold", int'(speed), 3);
        run(DB, 4'b0);

        // Pause: ball moves on the event tick, then freezes.
        run(DB, 4'b0001);
        chk("paused_on", int'(paused), 1);
        sx = m_x; sy = m_y;
        run(DB, 4'b0);
        run(10 - DB, 4'b0);
        chk("frozen_x", int'(ball_x), sx);
        chk("frozen_y", int'(ball_y), sy);
        run(DB, 4'b0001);
        chk("paused_off", int'(paused), 0);
        run(DB, 4'b0);

        // Centre event lands on the tick that would otherwise bounce.
        found = 0;
        for (guard = 0; guard < 600 && found == 0; guard++) begin
            if (ticks_to_bounce() == DB) found = 1;
            else run(1, 4'b0);
        end
        chk("centre_setup_found", found, 1);
        run(DB - 1, 4'b1000);
        pre_hits = m_hits;
        run(1, 4'b1000);
        chk("centre_x", int'(ball_x), 320);
        chk("centre_y", int'(ball_y), 240);
        chk("centre_no_bounce", int'(bounce), 0);
        chk("centre_hits", int'(hit_count), pre_hits);
        run(DB, 4'b0);

        // Randomized buttons with occasional back-to-back frame ticks.
        for (int i = 0; i < 300; i++) begin
            nb = btns;
            if ($urandom_range(0, 5) == 0) nb[$urandom_range(0, 3)] = ~nb[$urandom_range(0, 3)];
            if (nb == btns && $urandom_range(0, 2) == 0) begin
                tick(1'b1);
            end else begin
                btns = nb;
                tick(1'b0);
            end
        end

        // Asynchronous reset mid-frame, no clock edge in between.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ball_x", int'(ball_x), 320);
        chk("arst_ball_y", int'(ball_y), 240);
        chk("arst_speed", int'(speed), SPD0);
        chk("arst_paused", int'(paused), 0);
        chk("arst_bounce", int'(bounce), 0);
        chk("arst_hits", int'(hit_count), 0);
        btns = 4'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        run(3, 4'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
